intra_coeff_deserializer: RTL and testbench
===========================================

# intra_coeff_deserializer

Decoder-side front end for the intra loop. It accepts a serial stream of quantized 4x4 coefficient blocks in zigzag order over a valid/ready handshake and de-zigzags each block into raster order. Completed blocks are held in a two-bank ping-pong buffer and presented in parallel to the inverse quantizer / inverse transform / reconstructor chain, tagged with component, mode, macroblock number and chroma quadrant. It is the receiving end of the block stream the encoder loop produces: one 4x4 luma block, or an 8x8 chroma block split into four 4x4 quadrants.

## Interface
Parameters:
- COEFF_W, 8, coefficient width (signed).
- MBNUM_W, 32, macroblock number width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_coeff  in  COEFF_W  signed coefficient, zigzag order.
- s_first  in  1  marks beat 0 of a block.
- s_comp  in  2  component: 0 luma, 1 chroma B, 2 chroma R, 3 invalid. Sampled on the s_first beat.
- s_mode  in  3  prediction mode. Sampled on the s_first beat.
- s_mbnumber  in  MBNUM_W  macroblock number. Sampled on the s_first beat.
- m_valid  out  1  output block valid.
- m_ready  in  1  output block consumed when m_valid && m_ready.
- m_block  out  16 x COEFF_W  signed, raster order, index 0 = top-left.
- m_comp  out  2  tag of the presented block.
- m_mode  out  3  tag of the presented block.
- m_mbnumber  out  MBNUM_W  tag of the presented block.
- m_quadrant  out  2  chroma quadrant (0 TL, 1 TR, 2 BL, 3 BR); always 0 for luma.
- m_last  out  1  block completes its macroblock (every luma block; chroma quadrant 3).
- err_sync  out  1  one-cycle pulse on a framing error.

## Operation
- Two banks, each holding 16 coefficients plus the tags (comp, mode, mbnumber, quadrant, last) and a full flag.
- Pointers: wr_bank, rd_bank and a 4-bit beat index.
- s_ready = !full[wr_bank] (combinational).
- Accepted beat: s_coeff is written to bank[wr_bank] at raster position ZZ[idx], then idx increments.
- ZZ = {0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15}.
- Tags are written on the s_first beat.
- Beat 15 accepted: full[wr_bank] <= 1, wr_bank toggles, idx <= 0.
- m_valid = full[rd_bank]. All m_* outputs are driven from bank[rd_bank].
- On m_valid && m_ready: full[rd_bank] <= 0, rd_bank toggles.
- Quadrant counter qcnt[1:0] and last chroma component lastc, updated on each s_first beat:
  - Luma: quadrant tag is 0, last tag is 1; qcnt is untouched.
  - Chroma with qcnt != 0 and s_comp != lastc: err_sync pulses, the block is tagged quadrant 0, qcnt <= 1.
  - Chroma otherwise: the block is tagged quadrant qcnt, last = (qcnt == 3), qcnt increments (wraps 3 -> 0), lastc <= s_comp.
- Framing errors:
  - Beat with s_first = 0 while idx == 0: beat dropped, err_sync pulses.
  - s_first = 1 while idx != 0: partial block discarded, err_sync pulses, and the beat starts a new block at idx 0.
  - s_comp == 3 on the s_first beat: err_sync pulses and that beat plus the next 15 accepted beats are dropped. Accepted means s_valid && s_ready, and s_ready stays high while dropping. A drop flag counts these beats with idx. No bank is filled.
- Beats are never accepted into a full bank, so a bank cannot be filled and released in the same cycle.

## Timing
- Reset (reset low, asynchronous):
  - full[1:0] = 0, wr_bank = rd_bank = 0, idx = 0, qcnt = 0, drop = 0, err_sync = 0.
  - m_block and the m_* tags read 0 (bank contents cleared).
  - Resulting outputs: m_valid = 0, s_ready = 1.
  - A block partially received when reset asserts is lost.
- Latency: m_valid rises the cycle after beat 15 is accepted.
- Throughput: one beat per cycle with no bubbles while m_ready consumes at least one block per 16 cycles.
- With both banks full, s_ready = 0. It returns to 1 the cycle after a release.
- A release and the 16th beat of the other bank in the same cycle are both honoured; m_valid stays high for the next block.
- m_* outputs are stable while m_valid && !m_ready.
- err_sync is registered: it pulses in the cycle after the offending beat.

## Structure
- Package intra_dec_pkg holds:
  - the ZZ table as a localparam array;
  - comp encodings COMP_LUMA / COMP_CHB / COMP_CHR / COMP_BAD;
  - a typedef for the block tag struct (comp, mode, mbnumber, quadrant, last).
- One sub-module, coeff_bank: a 16-entry storage register file with indexed write and parallel read, plus its tag register. It is instantiated twice.

## Test plan
- Luma, s_coeff = 1..16 with s_first on beat 1, m_ready = 1 -> one cycle after beat 16: m_block = {1,2,6,7,3,5,8,13,4,9,12,14,10,11,15,16}, m_quadrant = 0, m_last = 1.
- Four chroma B quadrants back-to-back with m_ready = 0 -> s_ready falls after 32 beats. Then m_ready = 1 -> quadrants presented as 0,1,2,3, with m_last = 1 only on quadrant 3. s_ready returns the cycle after the first release.
- s_first re-asserted on beat 7 of a block -> err_sync pulses once, the partial block is not presented, and the following 16-beat block is presented correctly.
- reset pulsed low at beat 9 -> all outputs at reset values, and the next full block is presented with no residue of the earlier data.
- Continuous stream with m_ready = 1 -> s_ready never falls and a block is presented every 16 cycles.
- s_comp = 3 block, then a valid luma block -> a single err_sync pulse, no m_valid for the first 16 beats, and the luma block is presented normally.

Source files
------------

// File: rtl/intra_dec_pkg.sv
// Shared types and constants for the intra-loop coefficient deserializer:
// zigzag scan table, component encodings and the per-block tag record.
package intra_dec_pkg;

    localparam int NCOEFF      = 16;
    // Tag record carries the default macroblock number width; narrower ports zero-extend into it.
    localparam int TAG_MBNUM_W = 32;

    typedef enum logic [1:0] {
        COMP_LUMA = 2'd0,
        COMP_CHB  = 2'd1,
        COMP_CHR  = 2'd2,
        COMP_BAD  = 2'd3
    } comp_e;

    // Raster position of the n-th coefficient in 4x4 zigzag scan order.
    localparam logic [3:0] ZZ [NCOEFF] = '{
        4'd0,  4'd1,  4'd4,  4'd8,  4'd5,  4'd2,  4'd3,  4'd6,
        4'd9,  4'd12, 4'd13, 4'd10, 4'd7,  4'd11, 4'd14, 4'd15
    };

    typedef struct packed {
        comp_e                  comp;
        logic [2:0]             mode;
        logic [TAG_MBNUM_W-1:0] mbnumber;
        logic [1:0]             quadrant;
        logic                   last;
    } blk_tag_t;

endpackage

// File: rtl/coeff_bank.sv
// One ping-pong bank: 16 coefficients with indexed write and parallel read,
// plus the tag record of the block being assembled or held.
module coeff_bank
    import intra_dec_pkg::*;
#(
    parameter int COEFF_W = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            coeff_we_i,
    input  logic [3:0]                      coeff_addr_i,
    input  logic [COEFF_W-1:0]              coeff_i,
    input  logic                            tag_we_i,
    input  blk_tag_t                        tag_i,
    output logic [NCOEFF-1:0][COEFF_W-1:0]  coeffs_o,
    output blk_tag_t                        tag_o
);

    logic [NCOEFF-1:0][COEFF_W-1:0] coeffs_q;
    blk_tag_t                       tag_q;

    // NOTE: storage is reset on purpose so an idle output presents all zeros and no stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coeffs_q <= '0;
            tag_q    <= '0;
        end else begin
            if (coeff_we_i) coeffs_q[coeff_addr_i] <= coeff_i;
            if (tag_we_i)   tag_q                  <= tag_i;
        end
    end

    assign coeffs_o = coeffs_q;
    assign tag_o    = tag_q;

endmodule

// File: rtl/intra_coeff_deserializer.sv
// Receives zigzag-ordered 4x4 coefficient blocks over valid/ready, de-zigzags them
// into a two-bank ping-pong buffer and presents whole tagged blocks downstream.
module intra_coeff_deserializer
    import intra_dec_pkg::*;
#(
    parameter int COEFF_W = 8,
    parameter int MBNUM_W = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [COEFF_W-1:0]              s_coeff,
    input  logic                            s_first,
    input  logic [1:0]                      s_comp,
    input  logic [2:0]                      s_mode,
    input  logic [MBNUM_W-1:0]              s_mbnumber,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NCOEFF-1:0][COEFF_W-1:0]  m_block,
    output logic [1:0]                      m_comp,
    output logic [2:0]                      m_mode,
    output logic [MBNUM_W-1:0]              m_mbnumber,
    output logic [1:0]                      m_quadrant,
    output logic                            m_last,
    output logic                            err_sync
);

    logic [1:0] full_q,     full_d;
    logic       wr_bank_q,  wr_bank_d;
    logic       rd_bank_q,  rd_bank_d;
    logic [3:0] idx_q,      idx_d;
    logic [1:0] qcnt_q,     qcnt_d;
    comp_e      lastc_q,    lastc_d;
    logic       drop_q,     drop_d;
    logic       err_sync_q, err_sync_d;

    logic       accept;
    logic       release_blk;
    logic [3:0] beat_idx;
    logic       coeff_we;
    logic       tag_we;
    blk_tag_t   tag_new;

    logic [NCOEFF-1:0][COEFF_W-1:0] bank_coeffs [2];
    blk_tag_t                       bank_tag    [2];
    blk_tag_t                       rd_tag;

    assign s_ready     = !full_q[wr_bank_q];
    assign m_valid     = full_q[rd_bank_q];
    assign accept      = s_valid && s_ready;
    assign release_blk = m_valid && m_ready;

    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        idx_d      = idx_q;
        qcnt_d     = qcnt_q;
        lastc_d    = lastc_q;
        drop_d     = drop_q;
        err_sync_d = 1'b0;
        coeff_we   = 1'b0;
        tag_we     = 1'b0;
        beat_idx   = s_first ? 4'd0 : idx_q;
        tag_new    = '{comp:     comp_e'(s_comp),
                       mode:     s_mode,
                       mbnumber: TAG_MBNUM_W'(s_mbnumber),
                       quadrant: 2'd0,
                       last:     1'b1};

        if (release_blk) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end

        if (accept) begin
            if (drop_q) begin
                // Discarding an invalid-component block; idx wraps to 0 on its 16th beat.
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) drop_d = 1'b0;
            end else if (!s_first && idx_q == 4'd0) begin
                err_sync_d = 1'b1;
            end else if (s_first && comp_e'(s_comp) == COMP_BAD) begin
                err_sync_d = 1'b1;
                drop_d     = 1'b1;
                idx_d      = 4'd1;
            end else begin
                if (s_first) begin
                    err_sync_d = (idx_q != 4'd0);
                    tag_we     = 1'b1;
                    if (comp_e'(s_comp) != COMP_LUMA) begin
                        if (qcnt_q != 2'd0 && comp_e'(s_comp) != lastc_q) begin
                            err_sync_d   = 1'b1;
                            tag_new.last = 1'b0;
                            qcnt_d       = 2'd1;
                        end else begin
                            tag_new.quadrant = qcnt_q;
                            tag_new.last     = (qcnt_q == 2'd3);
                            qcnt_d           = qcnt_q + 2'd1;
                        end
                        lastc_d = comp_e'(s_comp);
                    end
                end
                coeff_we = 1'b1;
                idx_d    = beat_idx + 4'd1;
                if (beat_idx == 4'd15) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = !wr_bank_q;
                end
            end
        end
    end

    // NOTE: nonblocking assignments make every register sample pre-edge values, independent of order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            idx_q      <= 4'd0;
            qcnt_q     <= 2'd0;
            lastc_q    <= COMP_LUMA;
            drop_q     <= 1'b0;
            err_sync_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            idx_q      <= idx_d;
            qcnt_q     <= qcnt_d;
            lastc_q    <= lastc_d;
            drop_q     <= drop_d;
            err_sync_q <= err_sync_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        coeff_bank #(
            .COEFF_W (COEFF_W)
        ) u_bank (
            .clk          (clk),
            .rst_n        (reset),
            .coeff_we_i   (coeff_we && (wr_bank_q == 1'(b))),
            .coeff_addr_i (ZZ[beat_idx]),
            .coeff_i      (s_coeff),
            .tag_we_i     (tag_we && (wr_bank_q == 1'(b))),
            .tag_i        (tag_new),
            .coeffs_o     (bank_coeffs[b]),
            .tag_o        (bank_tag[b])
        );
    end

    assign rd_tag     = bank_tag[rd_bank_q];
    assign m_block    = bank_coeffs[rd_bank_q];
    assign m_comp     = rd_tag.comp;
    assign m_mode     = rd_tag.mode;
    assign m_mbnumber = MBNUM_W'(rd_tag.mbnumber);
    assign m_quadrant = rd_tag.quadrant;
    assign m_last     = rd_tag.last;
    assign err_sync   = err_sync_q;

endmodule

// File: tb/tb_intra_coeff_deserializer.sv
// Randomized and directed bench for intra_coeff_deserializer, scored against a
// beat-list reference model that rebuilds raster blocks by walking anti-diagonals.
module tb_intra_coeff_deserializer;

    localparam int COEFF_W = 8;
    localparam int MBNUM_W = 32;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        s_valid, s_ready, s_first;
    logic [COEFF_W-1:0]          s_coeff;
    logic [1:0]                  s_comp;
    logic [2:0]                  s_mode;
    logic [MBNUM_W-1:0]          s_mbnumber;
    logic                        m_valid, m_ready, m_last, err_sync;
    logic [15:0][COEFF_W-1:0]    m_block;
    logic [1:0]                  m_comp, m_quadrant;
    logic [2:0]                  m_mode;
    logic [MBNUM_W-1:0]          m_mbnumber;

    intra_coeff_deserializer #(.COEFF_W(COEFF_W), .MBNUM_W(MBNUM_W)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_coeff(s_coeff), .s_first(s_first),
        .s_comp(s_comp), .s_mode(s_mode), .s_mbnumber(s_mbnumber),
        .m_valid(m_valid), .m_ready(m_ready), .m_block(m_block), .m_comp(m_comp),
        .m_mode(m_mode), .m_mbnumber(m_mbnumber), .m_quadrant(m_quadrant),
        .m_last(m_last), .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0][COEFF_W-1:0] blk;
        logic [1:0]               comp;
        logic [2:0]               mode;
        logic [MBNUM_W-1:0]       mb;
        logic [1:0]               quad;
        logic                     last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur, popped, hold_exp;
    int         n_vec = 0, n_miss = 0;
    int         zz_pos[16];
    int         m_nbeats, m_drop, m_qcnt;
    logic [1:0] m_lastc;
    logic [COEFF_W-1:0] m_beats[16];
    int         exp_err = 0, got_err = 0, cycle = 0, stalls = 0;
    int         pop_t[$];
    bit         hold_v = 1'b0, rand_rdy = 1'b0;
    logic [15:0][COEFF_W-1:0] hold_blk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Zigzag scan: anti-diagonal d, odd diagonals run downward, even ones upward.
    function automatic void build_zz();
        int k = 0;
        for (int d = 0; d < 7; d++) begin
            int lo = (d > 3) ? d - 3 : 0;
            int hi = (d < 3) ? d : 3;
            if (d % 2 == 1) for (int r = lo; r <= hi; r++) begin zz_pos[k] = r * 4 + (d - r); k++; end
            else            for (int r = hi; r >= lo; r--) begin zz_pos[k] = r * 4 + (d - r); k++; end
        end
    endfunction

    function automatic void model_reset();
        m_nbeats = 0; m_drop = 0; m_qcnt = 0; m_lastc = 2'd0;
        exp_q.delete();
    endfunction

    function automatic void model_beat(input bit first, input logic [1:0] comp, input logic [2:0] mode,
                                       input logic [MBNUM_W-1:0] mb, input logic [COEFF_W-1:0] coeff);
        bit e = 1'b0, take = 1'b0;
        if (m_drop > 0) m_drop--;
        else if (!first && m_nbeats == 0) e = 1'b1;
        else if (!first) take = 1'b1;
        else begin
            e = (m_nbeats != 0);
            m_nbeats = 0;
            if (comp == 2'd3) begin e = 1'b1; m_drop = 15; end
            else begin
                take = 1'b1;
                cur.comp = comp; cur.mode = mode; cur.mb = mb;
                if (comp == 2'd0) begin cur.quad = 2'd0; cur.last = 1'b1; end
                else if (m_qcnt != 0 && comp != m_lastc) begin
                    e = 1'b1; cur.quad = 2'd0; cur.last = 1'b0; m_qcnt = 1; m_lastc = comp;
                end else begin
                    cur.quad = 2'(m_qcnt); cur.last = (m_qcnt == 3);
                    m_qcnt = (m_qcnt + 1) % 4; m_lastc = comp;
                end
            end
        end
        if (take) begin
            m_beats[m_nbeats] = coeff;
            m_nbeats++;
            if (m_nbeats == 16) begin
                for (int i = 0; i < 16; i++) cur.blk[zz_pos[i]] = m_beats[i];
                exp_q.push_back(cur);
                m_nbeats = 0;
            end
        end
        if (e) exp_err++;
    endfunction

    task automatic send_beat(input bit first, input logic [1:0] comp, input logic [2:0] mode,
                             input logic [MBNUM_W-1:0] mb, input logic [COEFF_W-1:0] coeff);
        int waited = 0;
        bit done = 1'b0;
        s_valid = 1'b1; s_first = first; s_comp = comp; s_mode = mode; s_mbnumber = mb; s_coeff = coeff;
        while (!done) begin
            @(negedge clk);
            if (s_ready) begin model_beat(first, comp, mode, mb, coeff); done = 1'b1; end
            else begin stalls++; waited++; end
            @(posedge clk); #1;
            if (!done && waited > 200) begin check("accept_timeout", 0, 1); done = 1'b1; end
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Non-first beats carry random tag values, which the design must ignore.
    task automatic send_block(input logic [1:0] comp, input logic [2:0] mode, input logic [MBNUM_W-1:0] mb,
                              input int nbeats, input bit seq, input int gap_pct);
        for (int i = 0; i < nbeats; i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle(1);
            if (i == 0) send_beat(1'b1, comp, mode, mb, seq ? COEFF_W'(1) : COEFF_W'($urandom));
            else send_beat(1'b0, 2'($urandom), 3'($urandom), $urandom,
                           seq ? COEFF_W'(i + 1) : COEFF_W'($urandom));
        end
    endtask

    always @(posedge clk) cycle++;

    always @(posedge clk) if (rand_rdy) begin #1; m_ready = ($urandom_range(0, 3) != 0); end

    always @(negedge clk) begin
        if (reset) begin
            if (err_sync) got_err++;
            if (hold_v && m_valid) begin
                check("hold_block", m_block, hold_blk);
                check("hold_mbnumber", m_mbnumber, hold_exp.mb);
            end
            if (m_valid && m_ready) begin
                check("queue_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    popped = exp_q.pop_front();
                    check("blk_data", m_block, popped.blk);
                    check("blk_comp", m_comp, popped.comp);
                    check("blk_mode", m_mode, popped.mode);
                    check("blk_mbnumber", m_mbnumber, popped.mb);
                    check("blk_quadrant", m_quadrant, popped.quad);
                    check("blk_last", m_last, popped.last);
                    pop_t.push_back(cycle);
                end
            end
            hold_v = m_valid && !m_ready;
            hold_blk = m_block;
            hold_exp.mb = m_mbnumber;
        end else hold_v = 1'b0;
    end

    initial begin
        logic [15:0][COEFF_W-1:0] t1_exp;
        int t1v[16] = '{1, 2, 6, 7, 3, 5, 8, 13, 4, 9, 12, 14, 10, 11, 15, 16};
        int e0, s0, p0;
        logic [MBNUM_W-1:0] mb = 32'd100;

        build_zz();
        model_reset();
        reset = 1'b0; s_valid = 1'b0; s_first = 1'b0; s_coeff = '0; s_comp = '0; s_mode = '0;
        s_mbnumber = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 1);
        check("rst_m_block", m_block, 0);
        check("rst_tags", {m_comp, m_mode, m_mbnumber, m_quadrant, m_last}, 0);
        check("rst_err_sync", err_sync, 0);
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;

        // Sequential luma block: known raster pattern and one-cycle latency.
        for (int i = 0; i < 16; i++) t1_exp[i] = COEFF_W'(t1v[i]);
        m_ready = 1'b1;
        send_block(2'd0, 3'd5, 32'h1234, 16, 1'b1, 0);
        s_valid = 1'b0;
        @(negedge clk);
        check("t1_latency_m_valid", m_valid, 1);
        check("t1_block", m_block, t1_exp);
        check("t1_quadrant", m_quadrant, 0);
        check("t1_last", m_last, 1);
        @(posedge clk); #1;

        // Two chroma B quadrants fill both banks, then release and finish the macroblock.
        m_ready = 1'b0;
        send_block(2'd1, 3'd2, 32'd7, 16, 1'b0, 0);
        send_block(2'd1, 3'd2, 32'd7, 16, 1'b0, 0);
        s_valid = 1'b0;
        @(negedge clk);
        check("t2_full_s_ready", s_ready, 0);
        check("t2_full_m_valid", m_valid, 1);
        @(posedge clk); #1 m_ready = 1'b1;
        @(negedge clk);
        check("t2_release_pending", s_ready, 0);
        @(negedge clk);
        check("t2_ready_back", s_ready, 1);
        @(posedge clk); #1;
        send_block(2'd1, 3'd2, 32'd7, 16, 1'b0, 0);
        send_block(2'd1, 3'd2, 32'd7, 16, 1'b0, 0);
        idle(3);
        check("t2_drained", exp_q.size(), 0);

        // s_first re-asserted on beat 7 discards the partial block.
        e0 = got_err;
        send_block(2'd0, 3'd1, 32'd8, 6, 1'b0, 0);
        send_block(2'd0, 3'd3, 32'd9, 16, 1'b0, 0);
        idle(3);
        check("t3_err_once", got_err - e0, 1);
        check("t3_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of beat 9.
        send_block(2'd0, 3'd4, 32'd10, 8, 1'b0, 0);
        s_valid = 1'b1; s_first = 1'b0; s_coeff = 8'h5a;
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("t4_m_valid", m_valid, 0);
        check("t4_s_ready", s_ready, 1);
        check("t4_m_block", m_block, 0);
        check("t4_tags", {m_comp, m_mode, m_mbnumber, m_quadrant, m_last}, 0);
        check("t4_err_sync", err_sync, 0);
        s_valid = 1'b0;
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #1;
        send_block(2'd0, 3'd6, 32'd11, 16, 1'b0, 0);
        idle(3);
        check("t4_drained", exp_q.size(), 0);

        // Continuous stream: no stalls and one block every 16 cycles.
        s0 = stalls;
        p0 = pop_t.size();
        for (int b = 0; b < 4; b++) send_block(2'd0, 3'(b), 32'(20 + b), 16, 1'b0, 0);
        idle(3);
        check("t5_no_stall", stalls - s0, 0);
        check("t5_block_count", pop_t.size() - p0, 4);
        for (int i = p0; i + 1 < pop_t.size(); i++) check("t5_spacing", pop_t[i + 1] - pop_t[i], 16);

        // Invalid component block is swallowed, following luma block is intact.
        e0 = got_err;
        send_block(2'd3, 3'd0, 32'd30, 16, 1'b0, 0);
        s_valid = 1'b0;
        @(negedge clk);
        check("t6_no_valid", m_valid, 0);
        @(posedge clk); #1;
        send_block(2'd0, 3'd7, 32'd31, 16, 1'b0, 0);
        idle(3);
        check("t6_err_once", got_err - e0, 1);
        check("t6_drained", exp_q.size(), 0);

        // Random well-formed traffic with gaps and random backpressure.
        rand_rdy = 1'b1;
        for (int g = 0; g < 30; g++) begin
            int r = $urandom_range(0, 9);
            mb++;
            if (r < 4) send_block(2'd0, 3'($urandom), mb, 16, 1'b0, 20);
            else if (r < 9) begin
                logic [1:0] c = 2'($urandom_range(1, 2));
                for (int q = 0; q < 4; q++) send_block(c, 3'($urandom), mb, 16, 1'b0, 20);
            end else send_block(2'd3, 3'($urandom), mb, 16, 1'b0, 20);
        end
        idle(1);
        rand_rdy = 1'b0;
        @(posedge clk); #2 m_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        idle(3);
        check("final_drained", exp_q.size(), 0);
        check("final_err_count", got_err, exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
